// File: rtl/datapath_pkg.sv
// Shared defaults and write-back entry layout for the datapath register file.
package datapath_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NREGS  = 16;
  localparam int DEF_NRD    = 4;
  localparam int DEF_AW     = $clog2(DEF_NREGS);
  localparam int MAX_WB_LAT = 4;

  // Entry layout at the default sizes; parametrised instances pass their own.
  typedef struct packed {
    logic                 valid;
    logic [DEF_AW-1:0]    addr;
    logic [DEF_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic int clamp_lat(input int lat);
    if (lat < 1)          return 1;
    if (lat > MAX_WB_LAT) return MAX_WB_LAT;
    return lat;
  endfunction

endpackage

// File: rtl/datapath_regfile_if.sv
// Decode/ALU-facing bus of the datapath register file.
interface datapath_regfile_if
  import datapath_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0]     zero_reg;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [1:0]           write;
  logic [AW-1:0]        Y1;
  logic [AW-1:0]        Y2;
  logic [2*WIDTH-1:0]   wdata;
  logic [1:0]           const_a;
  logic [WIDTH-1:0]     constant;
  logic [NREGS-1:0]     pending;
  logic                 wr_conflict;

  modport master (
    output zero_reg, rd_addr, write, Y1, Y2, wdata, const_a, constant,
    input  rd_data, pending, wr_conflict
  );

  modport slave (
    input  zero_reg, rd_addr, write, Y1, Y2, wdata, const_a, constant,
    output rd_data, pending, wr_conflict
  );

endinterface

// File: rtl/datapath_regfile_wb_pipe.sv
// Write-back shift pipe: stage 0 is the (conflict-squashed) request, later stages are
// in flight; the last stage is the one committed to the array at the next edge.
module regfile_wb_pipe
  import datapath_pkg::*;
#(
  parameter int  WB_LAT  = 1,
  parameter type entry_t = wb_entry_t
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  entry_t [1:0]              req,
  output entry_t [WB_LAT-1:0][1:0]  stage,
  output logic                      wr_conflict
);

  entry_t [1:0] ent;
  logic         conflict_d;
  logic         conflict_q;

  // Same-address pair: port 1 wins, so port 0 never enters the pipe.
  always_comb begin
    ent        = req;
    conflict_d = req[0].valid && req[1].valid && (req[0].addr == req[1].addr);
    if (conflict_d) ent[0].valid = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_q <= 1'b0;
    else        conflict_q <= conflict_d;
  end

  assign wr_conflict = conflict_q;

  if (WB_LAT > 1) begin : g_pipe
    entry_t [WB_LAT-1:1][1:0] pipe_d;
    entry_t [WB_LAT-1:1][1:0] pipe_q;

    always_comb begin
      pipe_d[1] = ent;
      for (int s = 2; s < WB_LAT; s++) pipe_d[s] = pipe_q[s-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= pipe_d;
    end

    assign stage = {pipe_q, ent};
  end else begin : g_direct
    assign stage = ent;
  end

endmodule

// File: rtl/datapath_regfile.sv
// Datapath register file: NRD combinational read ports, two write ports with constant
// injection, hardwired-zero mask and WB_LAT-cycle write-back with forwarding.
module datapath_regfile
  import datapath_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int WB_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  datapath_regfile_if.slave  bus
);

  localparam int AW  = $clog2(NREGS);
  localparam int LAT = clamp_lat(WB_LAT);

  typedef struct packed {
    logic             valid;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t [1:0]                req;
  entry_t [LAT-1:0][1:0]       stage;
  logic [NREGS-1:0][WIDTH-1:0] regs_d;
  logic [NREGS-1:0][WIDTH-1:0] regs_q;
  logic [1:0][WIDTH-1:0]       wd;
  logic [1:0][AW-1:0]          wa;
  logic [NRD-1:0][AW-1:0]      rd_idx;
  logic [NRD-1:0][WIDTH-1:0]   rd_val;
  logic [NREGS-1:0]            pend;

  assign wd           = bus.wdata;
  assign wa           = {bus.Y2, bus.Y1};
  assign rd_idx       = bus.rd_addr;
  assign bus.rd_data  = rd_val;
  assign bus.pending  = pend & ~bus.zero_reg;

  // NOTE: every variable written here gets a full default first so no latch is inferred.
  always_comb begin
    req = '0;
    for (int k = 0; k < 2; k++) begin
      req[k].addr  = wa[k];
      req[k].data  = bus.const_a[k] ? bus.constant : wd[k];
      req[k].valid = bus.write[k] && !bus.zero_reg[wa[k]];
    end
  end

  regfile_wb_pipe #(
    .WB_LAT  (LAT),
    .entry_t (entry_t)
  ) u_wb_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .stage       (stage),
    .wr_conflict (bus.wr_conflict)
  );

  // Port 1 is applied last so it wins a same-stage tie.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < 2; k++)
      if (stage[LAT-1][k].valid) regs_d[stage[LAT-1][k].addr] = stage[LAT-1][k].data;
  end

  // NOTE: the register array is reset explicitly because reads must return 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Stage 0 is this cycle's request and is never forwarded; oldest stage is scanned
  // first so the youngest matching entry overrides.
  always_comb begin
    pend   = '0;
    rd_val = '0;
    for (int s = 0; s < LAT; s++)
      for (int k = 0; k < 2; k++)
        if (s > 0 && stage[s][k].valid) pend[stage[s][k].addr] = 1'b1;
    for (int p = 0; p < NRD; p++) begin
      rd_val[p] = regs_q[rd_idx[p]];
      for (int s = LAT-1; s >= 0; s--)
        for (int k = 0; k < 2; k++)
          if (s > 0 && stage[s][k].valid && stage[s][k].addr == rd_idx[p])
            rd_val[p] = stage[s][k].data;
      if (bus.zero_reg[rd_idx[p]]) rd_val[p] = '0;
    end
  end

endmodule

// File: tb/tb_datapath_regfile.sv
// Directed bench for datapath_regfile at write-back latencies 1, 2 and 3.
module tb_datapath_regfile;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  datapath_regfile_if #(.WIDTH(32), .NREGS(16), .NRD(4)) b1 ();
  datapath_regfile_if #(.WIDTH(32), .NREGS(16), .NRD(4)) b2 ();
  datapath_regfile_if #(.WIDTH(32), .NREGS(16), .NRD(4)) b3 ();

  datapath_regfile #(.WIDTH(32), .NREGS(16), .NRD(4), .WB_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  datapath_regfile #(.WIDTH(32), .NREGS(16), .NRD(4), .WB_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));
  datapath_regfile #(.WIDTH(32), .NREGS(16), .NRD(4), .WB_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    b1.zero_reg = 16'h0001; b1.rd_addr = '0; b1.write = '0; b1.Y1 = '0; b1.Y2 = '0;
    b1.wdata = '0; b1.const_a = '0; b1.constant = '0;
    b2.zero_reg = 16'h0001; b2.rd_addr = '0; b2.write = '0; b2.Y1 = '0; b2.Y2 = '0;
    b2.wdata = '0; b2.const_a = '0; b2.constant = '0;
    b3.zero_reg = 16'h0001; b3.rd_addr = '0; b3.write = '0; b3.Y1 = '0; b3.Y2 = '0;
    b3.wdata = '0; b3.const_a = '0; b3.constant = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_lat1",    b1.rd_data[31:0], 32'h0);
    check("rst_pend_lat3",  {16'h0, b3.pending}, 32'h0);
    check("rst_conf_lat1",  {31'h0, b1.wr_conflict}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // LAT1: constant injection, visible at the next edge, current request not forwarded
    tick();
    b1.rd_addr = 16'h3021;
    b1.write = 2'b01; b1.Y1 = 4'd1; b1.const_a = 2'b01; b1.constant = 32'd5;
    b1.wdata = {32'h0, 32'hDEAD};
    tick();
    b1.Y1 = 4'd2; b1.constant = 32'd7;
    #1;
    check("t1_reg1_after1",   b1.rd_data[31:0], 32'd5);
    check("t1_no_fwd_reg2",   b1.rd_data[63:32], 32'd0);
    check("t1_pend_lat1",     {16'h0, b1.pending}, 32'h0);
    tick();
    b1.write = 2'b00; b1.const_a = 2'b00;
    #1;
    check("t1_reg1",          b1.rd_data[31:0], 32'd5);
    check("t1_reg2",          b1.rd_data[63:32], 32'd7);
    check("t1_reg0_zero",     b1.rd_data[95:64], 32'd0);
    check("t1_reg3_unwritten", b1.rd_data[127:96], 32'd0);

    // LAT1: same-address pair, port 1 wins, conflict pulse one cycle
    b1.Y1 = 4'd4; b1.Y2 = 4'd4; b1.wdata = {32'h22, 32'h11}; b1.write = 2'b11;
    b1.rd_addr = 16'h0004;
    #1;
    check("t3_conf_before",   {31'h0, b1.wr_conflict}, 32'h0);
    tick();
    b1.write = 2'b00;
    #1;
    check("t3_reg4",          b1.rd_data[31:0], 32'h22);
    check("t3_conf_pulse",    {31'h0, b1.wr_conflict}, 32'h1);
    tick();
    check("t3_conf_cleared",  {31'h0, b1.wr_conflict}, 32'h0);

    // LAT1: both ports to different regs, port 1 takes the constant
    b1.Y1 = 4'd6; b1.Y2 = 4'd7; b1.wdata = {32'h77, 32'h66}; b1.const_a = 2'b10;
    b1.constant = 32'h99; b1.write = 2'b11; b1.rd_addr = 16'h0076;
    tick();
    b1.write = 2'b00; b1.const_a = 2'b00;
    #1;
    check("inj_reg6_wdata",   b1.rd_data[31:0], 32'h66);
    check("inj_reg7_const",   b1.rd_data[63:32], 32'h99);
    check("inj_no_conflict",  {31'h0, b1.wr_conflict}, 32'h0);

    // LAT2: back-to-back writes to reg5, newest forwarded, newest survives
    b2.rd_addr = 16'h0005;
    b2.write = 2'b01; b2.Y1 = 4'd5; b2.wdata = {32'h0, 32'd1};
    tick();
    b2.wdata = {32'h0, 32'd2};
    #1;
    check("t5_fwd_first",     b2.rd_data[31:0], 32'd1);
    check("t5_pend_first",    {16'h0, b2.pending}, 32'h0020);
    tick();
    b2.write = 2'b00;
    #1;
    check("t5_fwd_second",    b2.rd_data[31:0], 32'd2);
    check("t5_pend_second",   {16'h0, b2.pending}, 32'h0020);
    tick();
    check("t5_final",         b2.rd_data[31:0], 32'd2);
    check("t5_pend_clear",    {16'h0, b2.pending}, 32'h0);

    // LAT3: reg3=0xAB, pending while in flight, forwarded, committed on edge 3
    b3.rd_addr = 16'h0003;
    b3.write = 2'b01; b3.Y1 = 4'd3; b3.wdata = {32'h0, 32'hAB};
    #1;
    check("t2_req_no_fwd",    b3.rd_data[31:0], 32'h0);
    check("t2_req_no_pend",   {16'h0, b3.pending}, 32'h0);
    tick();
    b3.write = 2'b00;
    #1;
    check("t2_fwd_c1",        b3.rd_data[31:0], 32'hAB);
    check("t2_pend_c1",       {16'h0, b3.pending}, 32'h0008);
    tick();
    check("t2_fwd_c2",        b3.rd_data[31:0], 32'hAB);
    check("t2_pend_c2",       {16'h0, b3.pending}, 32'h0008);
    tick();
    check("t2_committed",     b3.rd_data[31:0], 32'hAB);
    check("t2_pend_clear",    {16'h0, b3.pending}, 32'h0);

    // LAT3: writes to hardwired-zero reg0 are dropped
    b3.rd_addr = 16'h0000;
    b3.write = 2'b01; b3.Y1 = 4'd0; b3.wdata = {32'h0, 32'h55};
    tick();
    b3.write = 2'b00;
    #1;
    check("t4_pend_reg0",     {16'h0, b3.pending}, 32'h0);
    check("t4_rd_reg0",       b3.rd_data[31:0], 32'h0);
    tick();
    tick();
    tick();
    check("t4_reg0_after",    b3.rd_data[31:0], 32'h0);

    // LAT3: masking reg1 mid-flight hides it; the entry still commits
    b3.rd_addr = 16'h0001;
    b3.write = 2'b01; b3.Y1 = 4'd1; b3.wdata = {32'h0, 32'h77};
    tick();
    b3.write = 2'b00;
    #1;
    check("mask_fwd",         b3.rd_data[31:0], 32'h77);
    check("mask_pend",        {16'h0, b3.pending}, 32'h0002);
    b3.zero_reg = 16'h0003;
    #1;
    check("mask_rd_zero",     b3.rd_data[31:0], 32'h0);
    check("mask_pend_hidden", {16'h0, b3.pending}, 32'h0);
    tick();
    b3.zero_reg = 16'h0001;
    #1;
    check("unmask_fwd",       b3.rd_data[31:0], 32'h77);
    tick();
    check("unmask_commit",    b3.rd_data[31:0], 32'h77);
    check("unmask_pend",      {16'h0, b3.pending}, 32'h0);

    // LAT3: reset with two writes in flight discards them
    b3.write = 2'b01; b3.Y1 = 4'd8; b3.wdata = {32'h0, 32'h88};
    tick();
    b3.Y1 = 4'd9; b3.wdata = {32'h0, 32'h99};
    tick();
    b3.write = 2'b00; b3.rd_addr = 16'h9831;
    #1;
    check("t6_pend_two",      {16'h0, b3.pending}, 32'h0300);
    check("t6_rd_reg1",       b3.rd_data[31:0], 32'h77);
    check("t6_rd_reg3",       b3.rd_data[63:32], 32'hAB);
    check("t6_fwd_reg8",      b3.rd_data[95:64], 32'h88);
    check("t6_fwd_reg9",      b3.rd_data[127:96], 32'h99);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pend",      {16'h0, b3.pending}, 32'h0);
    check("t6_rst_reg1",      b3.rd_data[31:0], 32'h0);
    check("t6_rst_reg3",      b3.rd_data[63:32], 32'h0);
    check("t6_rst_reg8",      b3.rd_data[95:64], 32'h0);
    check("t6_rst_lat1_reg7", b1.rd_data[63:32], 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("t6_no_stale_8",    b3.rd_data[95:64], 32'h0);
    check("t6_no_stale_9",    b3.rd_data[127:96], 32'h0);
    check("t6_pend_after",    {16'h0, b3.pending}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
